// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: disparity width, control tokens, stage-2 bundle, popcount helper.
package tmds_pkg;

  localparam int CNT_W = 5;

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  // Stage-2 output: transition-minimised word, its ones/zeros counts, delayed control.
  typedef struct packed {
    logic [8:0] q_m;
    logic [3:0] n1;
    logic [3:0] n0;
    logic       vde;
    logic       c1;
    logic       c0;
  } qm_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Stages 1-2 of the TMDS encoder: byte -> registered q_m[8:0] with ones/zeros counts.
// Two-cycle latency, free-running (no handshake); control bits travel alongside.
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic       video_data_enable,
  input  logic       c0,
  input  logic       c1,
  input  logic [7:0] input_byte,
  output qm_t        qm
);

  logic [7:0] d_s1;
  logic [3:0] n1d_s1;
  logic       vde_s1;
  logic       c0_s1;
  logic       c1_s1;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      d_s1   <= '0;
      n1d_s1 <= '0;
      vde_s1 <= 1'b0;
      c0_s1  <= 1'b0;
      c1_s1  <= 1'b0;
    end else begin
      d_s1   <= input_byte;
      n1d_s1 <= popcount8(input_byte);
      vde_s1 <= video_data_enable;
      c0_s1  <= c0;
      c1_s1  <= c1;
    end
  end

  logic       use_xnor;
  logic [8:0] q_m;
  logic [3:0] n1q;

  // XNOR chain is chosen for ones-heavy bytes to minimise transitions.
  always_comb begin
    use_xnor = (n1d_s1 > 4'd4) || ((n1d_s1 == 4'd4) && !d_s1[0]);
    q_m      = '0;
    q_m[0]   = d_s1[0];
    for (int i = 1; i < 8; i++) begin
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ d_s1[i]) : (q_m[i-1] ^ d_s1[i]);
    end
    q_m[8] = ~use_xnor;
    n1q    = popcount8(q_m[7:0]);
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      qm <= '0;
    end else begin
      qm.q_m <= q_m;
      qm.n1  <= n1q;
      qm.n0  <= 4'd8 - n1q;
      qm.vde <= vde_s1;
      qm.c1  <= c1_s1;
      qm.c0  <= c0_s1;
    end
  end

endmodule

// File: rtl/tmds_byte_encoder.sv
// DVI TMDS channel encoder, 3-cycle fixed pipeline, no backpressure; stage 3 does DC balance.
// TMDS_DISPARITY_OUT_EN adds the registered running disparity as an output.
module tmds_byte_encoder
  import tmds_pkg::*;
(
  input  logic                    pixel_clock,
  input  logic                    reset,
  input  logic                    video_data_enable,
  input  logic                    c0,
  input  logic                    c1,
  input  logic [7:0]              input_byte,
  output logic [9:0]              output_tmds
`ifdef TMDS_DISPARITY_OUT_EN
  ,
  output logic signed [CNT_W-1:0] disparity
`endif
);

  localparam logic signed [CNT_W-1:0] TWO  = 5'sd2;
  localparam logic signed [CNT_W-1:0] ZERO = 5'sd0;

  qm_t qm;

  tmds_qm_stage u_qm_stage (
    .pixel_clock       (pixel_clock),
    .reset             (reset),
    .video_data_enable (video_data_enable),
    .c0                (c0),
    .c1                (c1),
    .input_byte        (input_byte),
    .qm                (qm)
  );

  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_next;
  logic signed [CNT_W-1:0] diff;
  logic [9:0]              sym_next;
  logic                    qm8;

  always_comb begin
    qm8      = qm.q_m[8];
    diff     = $signed({1'b0, qm.n1}) - $signed({1'b0, qm.n0});
    sym_next = TOKEN_00;
    cnt_next = ZERO;
    if (qm.vde) begin
      if ((cnt == ZERO) || (qm.n1 == qm.n0)) begin
        sym_next = {~qm8, qm8, qm8 ? qm.q_m[7:0] : ~qm.q_m[7:0]};
        cnt_next = qm8 ? (cnt + diff) : (cnt - diff);
      end else if ((!cnt[CNT_W-1] && (qm.n1 > qm.n0)) ||
                   ( cnt[CNT_W-1] && (qm.n0 > qm.n1))) begin
        // Inverting pulls the running disparity back toward zero.
        sym_next = {1'b1, qm8, ~qm.q_m[7:0]};
        cnt_next = cnt - diff + (qm8 ? TWO : ZERO);
      end else begin
        sym_next = {1'b0, qm8, qm.q_m[7:0]};
        cnt_next = cnt + diff - (qm8 ? ZERO : TWO);
      end
    end else begin
      case ({qm.c1, qm.c0})
        2'b00:   sym_next = TOKEN_00;
        2'b01:   sym_next = TOKEN_01;
        2'b10:   sym_next = TOKEN_10;
        default: sym_next = TOKEN_11;
      endcase
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      output_tmds <= TOKEN_00;
      cnt         <= ZERO;
    end else begin
      output_tmds <= sym_next;
      cnt         <= cnt_next;
    end
  end

`ifdef TMDS_DISPARITY_OUT_EN
  assign disparity = cnt;
`endif

endmodule

// File: tb/tb_tmds_byte_encoder.sv
// Scoreboard bench for tmds_byte_encoder: directed vectors plus a behavioural model for ramps.
module tb_tmds_byte_encoder;

  logic       pixel_clock = 1'b0;
  logic       reset = 1'b1;
  logic       video_data_enable = 1'b0;
  logic       c0 = 1'b0;
  logic       c1 = 1'b0;
  logic [7:0] input_byte = 8'h00;
  logic [9:0] output_tmds;
`ifdef TMDS_DISPARITY_OUT_EN
  logic signed [4:0] disparity;
`endif

  tmds_byte_encoder dut (
    .pixel_clock       (pixel_clock),
    .reset             (reset),
    .video_data_enable (video_data_enable),
    .c0                (c0),
    .c1                (c1),
    .input_byte        (input_byte),
    .output_tmds       (output_tmds)
`ifdef TMDS_DISPARITY_OUT_EN
    ,
    .disparity         (disparity)
`endif
  );

  always #5 pixel_clock = ~pixel_clock;

  typedef struct {
    logic [9:0] sym;
    int         cnt;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         model_cnt = 0;
  logic       issued = 1'b0;
  logic [2:0] v_d = 3'b000;
  logic [2:0] rp = 3'b000;

  // Output-valid tracking: a sample issued before edge k is visible after edge k+2.
  always @(posedge pixel_clock) begin
    v_d <= reset ? 3'b000 : {v_d[1:0], issued};
    rp  <= {rp[1:0], reset};
  end

  always @(negedge pixel_clock) begin
    exp_t e;
    if (|rp) begin
      total++;
      if (output_tmds !== 10'h354) begin
        bad++;
        $display("FAIL reset_token: got %h want 354", output_tmds);
      end
`ifdef TMDS_DISPARITY_OUT_EN
      total++;
      if (disparity !== 5'sd0) begin
        bad++;
        $display("FAIL reset_cnt: got %0d want 0", disparity);
      end
`endif
    end else if (v_d[2]) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h with empty scoreboard", output_tmds);
      end else begin
        e = sb.pop_front();
        total++;
        if (output_tmds !== e.sym) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.tag, output_tmds, e.sym);
        end
`ifdef TMDS_DISPARITY_OUT_EN
        total++;
        if (int'(disparity) != e.cnt) begin
          bad++;
          $display("FAIL %s_cnt: got %0d want %0d", e.tag, disparity, e.cnt);
        end
`endif
      end
    end
  end

  function automatic logic [9:0] model(input logic vde, input logic [1:0] c,
                                       input logic [7:0] d, input int cin, output int cout);
    int         ones, n1, n0;
    bit         xn;
    logic [8:0] qm;
    if (!vde) begin
      cout = 0;
      case (c)
        2'b00:   return 10'h354;
        2'b01:   return 10'h0AB;
        2'b10:   return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
    n0 = 8 - n1;
    if (cin == 0 || n1 == n0) begin
      cout = qm[8] ? cin + n1 - n0 : cin + n0 - n1;
      return {!qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
    end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
      cout = cin + 2 * int'(qm[8]) + n0 - n1;
      return {1'b1, qm[8], ~qm[7:0]};
    end
    cout = cin + n1 - n0 - 2 * int'(!qm[8]);
    return {1'b0, qm[8], qm[7:0]};
  endfunction

  task automatic step();
    @(posedge pixel_clock);
    #2;
  endtask

  task automatic drive(input logic vde, input logic [1:0] c, input logic [7:0] d);
    video_data_enable = vde;
    c1                = c[1];
    c0                = c[0];
    input_byte        = d;
    issued            = 1'b1;
  endtask

  task automatic issue_hand(input logic vde, input logic [1:0] c, input logic [7:0] d,
                            input logic [9:0] sym, input int cnt, input string tag);
    exp_t e;
    drive(vde, c, d);
    e.sym = sym; e.cnt = cnt; e.tag = tag;
    sb.push_back(e);
    model_cnt = cnt;
    step();
  endtask

  task automatic issue_model(input logic vde, input logic [1:0] c, input logic [7:0] d,
                             input string tag);
    exp_t e;
    int   nc;
    drive(vde, c, d);
    e.sym = model(vde, c, d, model_cnt, nc);
    e.cnt = nc; e.tag = tag;
    model_cnt = nc;
    sb.push_back(e);
    step();
  endtask

  task automatic do_reset(input int n);
    issued = 1'b0;
    reset  = 1'b1;
    step();
    sb.delete();
    repeat (n - 1) step();
    reset     = 1'b0;
    model_cnt = 0;
  endtask

  // Hand-computed 0x00 stream from zero disparity.
  logic [9:0] t1_sym [10] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100,
                              10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h100};
  int         t1_cnt [10] = '{-8, 2, -6, 4, -4, 6, -2, 8, 0, -8};
  logic [9:0] t2_sym [4]  = '{10'h200, 10'h0FF, 10'h0FF, 10'h200};
  int         t2_cnt [4]  = '{-8, -2, 4, -4};
  logic [9:0] t4_sym [4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  initial begin
    int budget;
    step();
    do_reset(3);

    for (int i = 0; i < 10; i++) issue_hand(1'b1, 2'b00, 8'h00, t1_sym[i], t1_cnt[i], "zeros");

    do_reset(2);
    for (int i = 0; i < 4; i++) issue_hand(1'b1, 2'b00, 8'hFF, t2_sym[i], t2_cnt[i], "ones");

    for (int i = 0; i < 4; i++) begin
      logic [1:0] cc;
      cc = 2'(i);
      issue_hand(1'b0, cc, 8'hA5, t4_sym[i], 0, "token");
    end

    issue_hand(1'b1, 2'b00, 8'h00, 10'h100, -8, "resume");
    issue_hand(1'b1, 2'b00, 8'h00, 10'h3FF, 2, "resume");
    issue_hand(1'b1, 2'b00, 8'h00, 10'h100, -6, "resume");

    for (int i = 0; i < 256; i++) issue_model(1'b1, 2'b00, 8'(i), "ramp");

    for (int i = 0; i < 60; i++) issue_model(1'b1, 2'b00, 8'(i * 7 + 3), "ramp2");
    do_reset(2);
    issue_hand(1'b1, 2'b00, 8'h00, 10'h100, -8, "post_reset");
    issue_hand(1'b1, 2'b00, 8'h00, 10'h3FF, 2, "post_reset");
    issue_model(1'b1, 2'b00, 8'h5A, "post_reset");

    issued            = 1'b0;
    video_data_enable = 1'b0;
    budget = 0;
    while (sb.size() != 0 && budget < 10) begin
      step();
      budget++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
